// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants for the regfile_sb register file: default geometry,
// the address-width derivation and the reset/zero value used for storage,
// the zero register and the scoreboard flags.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 4;

   // Zero value; replicated to the needed width where used.
   localparam logic ZERO_BIT = 1'b0;

   // Scoreboard flag encoding, one bit per register.
   localparam logic BUSY_FREE     = 1'b0;
   localparam logic BUSY_RESERVED = 1'b1;

   // Address width for a register count; at least one bit.
   function automatic int addr_w(input int num_regs);
      return (num_regs > 2) ? $clog2(num_regs) : 1;
   endfunction

endpackage

// File: rtl/regfile_sb_onehot_decoder.sv
// onehot_decoder
// Binary-to-one-hot decoder with enable. Produces all zeros when the
// enable is low, otherwise a single set bit at position i_addr.
// Ports:
//   i_en      decode enable
//   i_addr    binary index, ADDR_W bits
//   o_onehot  one-hot result, 2**ADDR_W bits
module onehot_decoder #(
   parameter int ADDR_W = 2
) (
   input  logic                   i_en,
   input  logic [ADDR_W-1:0]      i_addr,
   output logic [2**ADDR_W-1:0]   o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// NUM_REGS x DATA_W register file with one synchronous write port, two
// combinational read ports with write-to-read bypass, an optional
// hard-wired zero register and a per-register busy scoreboard.
// Reserve sets a busy bit on the next edge; a write releases it. When
// both target the same register in one cycle the reserve wins.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data        write port (also releases busy)
//   rd_addr_a, rd_data_a, rd_busy_a  read port A
//   rd_addr_b, rd_data_b, rd_busy_b  read port B
//   rsv_en, rsv_addr               reserve port
//   busy_vec                       full scoreboard, bit i = register i busy
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int ZERO_REG = 0,
   localparam int ADDR_W   = addr_w(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   output logic [DATA_W-1:0]   rd_data_a,
   output logic                rd_busy_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic                rd_busy_b,
   input  logic                rsv_en,
   input  logic [ADDR_W-1:0]   rsv_addr,
   output logic [NUM_REGS-1:0] busy_vec
);

   // Bit 0 is masked out of every write/reserve vector when register 0
   // is hard-wired, so it is never stored, bypassed or marked busy.
   localparam logic [NUM_REGS-1:0] ZMASK =
      (ZERO_REG != 0) ? NUM_REGS'(1) : '0;

   localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{ZERO_BIT}};

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;

   logic [NUM_REGS-1:0] w_wr_sel;
   logic [NUM_REGS-1:0] w_rsv_sel;
   logic [NUM_REGS-1:0] w_wr_we;
   logic [NUM_REGS-1:0] w_rsv_set;
   logic                w_byp_a;
   logic                w_byp_b;

   onehot_decoder #(.ADDR_W(ADDR_W)) u_wr_dec (
      .i_en     (wr_en),
      .i_addr   (wr_addr),
      .o_onehot (w_wr_sel)
   );

   onehot_decoder #(.ADDR_W(ADDR_W)) u_rsv_dec (
      .i_en     (rsv_en),
      .i_addr   (rsv_addr),
      .o_onehot (w_rsv_sel)
   );

   assign w_wr_we   = w_wr_sel  & ~ZMASK;
   assign w_rsv_set = w_rsv_sel & ~ZMASK;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= ZERO_WORD;
         end
         r_busy <= {NUM_REGS{BUSY_FREE}};
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_we[i]) begin
               r_regs[i] <= wr_data;
            end
            // Set after clear: a same-cycle reserve overrides the release.
            if (w_rsv_set[i]) begin
               r_busy[i] <= BUSY_RESERVED;
            end else if (w_wr_we[i]) begin
               r_busy[i] <= BUSY_FREE;
            end
         end
      end
   end

   // A port bypasses exactly when the (masked) write targets its address,
   // which also hides that register's busy bit in the same cycle.
   assign w_byp_a = w_wr_we[rd_addr_a];
   assign w_byp_b = w_wr_we[rd_addr_b];

   assign rd_data_a = ZMASK[rd_addr_a] ? ZERO_WORD :
                      w_byp_a          ? wr_data   : r_regs[rd_addr_a];
   assign rd_data_b = ZMASK[rd_addr_b] ? ZERO_WORD :
                      w_byp_b          ? wr_data   : r_regs[rd_addr_b];

   assign rd_busy_a = r_busy[rd_addr_a] & ~w_byp_a;
   assign rd_busy_b = r_busy[rd_addr_b] & ~w_byp_b;

   assign busy_vec  = r_busy & ~ZMASK;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 0: default 4 x 32, no zero register
   logic        reset0, wr_en0, rsv_en0;
   logic [1:0]  wr_addr0, rd_addr_a0, rd_addr_b0, rsv_addr0;
   logic [31:0] wr_data0, rd_data_a0, rd_data_b0;
   logic        rd_busy_a0, rd_busy_b0;
   logic [3:0]  busy_vec0;

   // DUT 1: 8 x 16 with hard-wired zero register
   logic        reset1, wr_en1, rsv_en1;
   logic [2:0]  wr_addr1, rd_addr_a1, rd_addr_b1, rsv_addr1;
   logic [15:0] wr_data1, rd_data_a1, rd_data_b1;
   logic        rd_busy_a1, rd_busy_b1;
   logic [7:0]  busy_vec1;

   regfile_sb u_dut0 (
      .clk(clk), .reset(reset0), .wr_en(wr_en0), .wr_addr(wr_addr0),
      .wr_data(wr_data0), .rd_addr_a(rd_addr_a0), .rd_data_a(rd_data_a0),
      .rd_busy_a(rd_busy_a0), .rd_addr_b(rd_addr_b0), .rd_data_b(rd_data_b0),
      .rd_busy_b(rd_busy_b0), .rsv_en(rsv_en0), .rsv_addr(rsv_addr0),
      .busy_vec(busy_vec0)
   );

   regfile_sb #(.NUM_REGS(8), .DATA_W(16), .ZERO_REG(1)) u_dut1 (
      .clk(clk), .reset(reset1), .wr_en(wr_en1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
      .rd_busy_a(rd_busy_a1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1),
      .rd_busy_b(rd_busy_b1), .rsv_en(rsv_en1), .rsv_addr(rsv_addr1),
      .busy_vec(busy_vec1)
   );

   // Signal codes for the scoreboard
   localparam int RDA0 = 0, RDB0 = 1, BSA0 = 2, BSB0 = 3, BVEC0 = 4;
   localparam int RDA1 = 5, RDB1 = 6, BSA1 = 7, BSB1 = 8, BVEC1 = 9;

   typedef struct {
      string       nm;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   exp_t mon_e;
   logic [31:0] mon_act;

   task automatic expect_v(input string nm, input int sig, input logic [31:0] val);
      exp_t e;
      e.nm = nm; e.sig = sig; e.val = val;
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] get_act(input int sig);
      case (sig)
         RDA0:  return rd_data_a0;
         RDB0:  return rd_data_b0;
         BSA0:  return {31'd0, rd_busy_a0};
         BSB0:  return {31'd0, rd_busy_b0};
         BVEC0: return {28'd0, busy_vec0};
         RDA1:  return {16'd0, rd_data_a1};
         RDB1:  return {16'd0, rd_data_b1};
         BSA1:  return {31'd0, rd_busy_a1};
         BSB1:  return {31'd0, rd_busy_b1};
         BVEC1: return {24'd0, busy_vec1};
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   // Monitor: outputs are presented every cycle; compare whatever the
   // stimulus queued for this cycle, mid-cycle on the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_e   = exp_q.pop_front();
         mon_act = get_act(mon_e.sig);
         total++;
         if (mon_act !== mon_e.val) begin
            bad++;
            $display("FAIL %s: got %h want %h", mon_e.nm, mon_act, mon_e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      reset0 = 0; wr_en0 = 0; rsv_en0 = 0;
   endtask

   task automatic idle1();
      reset1 = 0; wr_en1 = 0; rsv_en1 = 0;
   endtask

   initial begin
      reset0 = 1; wr_en0 = 0; wr_addr0 = 0; wr_data0 = 0;
      rd_addr_a0 = 0; rd_addr_b0 = 0; rsv_en0 = 0; rsv_addr0 = 0;
      reset1 = 1; wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0;
      rd_addr_a1 = 0; rd_addr_b1 = 0; rsv_en1 = 0; rsv_addr1 = 0;
      step();

      // ---- DUT 0 ----
      idle0(); idle1(); rd_addr_a0 = 2; rd_addr_b0 = 3;
      expect_v("rst_rda", RDA0, 0);
      expect_v("rst_rdb", RDB0, 0);
      expect_v("rst_bvec", BVEC0, 0);
      expect_v("rst_bsa", BSA0, 0);
      expect_v("rst_bsb", BSB0, 0);
      step();

      wr_en0 = 1; wr_addr0 = 1; wr_data0 = 32'hDEADBEEF; rd_addr_a0 = 0; rd_addr_b0 = 2;
      expect_v("wr_other_rda", RDA0, 0);
      step();
      idle0(); rd_addr_a0 = 1; rd_addr_b0 = 2;
      expect_v("readback_r1", RDA0, 32'hDEADBEEF);
      expect_v("readback_r2", RDB0, 0);
      step();

      wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'h12345678; rd_addr_a0 = 3; rd_addr_b0 = 3;
      expect_v("byp_a", RDA0, 32'h12345678);
      expect_v("byp_b", RDB0, 32'h12345678);
      step();
      idle0();
      expect_v("stored_a_r3", RDA0, 32'h12345678);
      expect_v("stored_b_r3", RDB0, 32'h12345678);
      step();

      rsv_en0 = 1; rsv_addr0 = 2; rd_addr_a0 = 2; rd_addr_b0 = 1;
      expect_v("rsv_cycle_bvec", BVEC0, 0);
      expect_v("rsv_cycle_bsa", BSA0, 0);
      step();
      idle0();
      expect_v("rsv_after_bvec", BVEC0, 4'b0100);
      expect_v("rsv_after_bsa", BSA0, 1);
      expect_v("rsv_other_bsb", BSB0, 0);
      step();
      wr_en0 = 1; wr_addr0 = 2; wr_data0 = 32'hA5; rd_addr_a0 = 2; rd_addr_b0 = 2;
      expect_v("release_bsa", BSA0, 0);
      expect_v("release_bsb", BSB0, 0);
      expect_v("release_rda", RDA0, 32'hA5);
      expect_v("release_bvec_pre", BVEC0, 4'b0100);
      step();
      idle0();
      expect_v("release_bvec_post", BVEC0, 0);
      expect_v("release_stored", RDA0, 32'hA5);
      step();

      rsv_en0 = 1; rsv_addr0 = 1; wr_en0 = 1; wr_addr0 = 1; wr_data0 = 32'h55; rd_addr_a0 = 1;
      expect_v("coll_byp", RDA0, 32'h55);
      expect_v("coll_bsa", BSA0, 0);
      step();
      idle0();
      expect_v("coll_bvec", BVEC0, 4'b0010);
      expect_v("coll_stored", RDA0, 32'h55);
      expect_v("coll_bsa_after", BSA0, 1);
      step();

      // re-reserve busy r1 and reserve r0 (allowed when no zero reg)
      rsv_en0 = 1; rsv_addr0 = 1;
      step();
      rsv_addr0 = 0;
      expect_v("rersv_bvec", BVEC0, 4'b0010);
      step();
      idle0(); rd_addr_b0 = 0;
      expect_v("rsv_r0_bvec", BVEC0, 4'b0011);
      expect_v("rsv_r0_bsb", BSB0, 1);
      step();

      // reset beats same-cycle write and reserve
      reset0 = 1; wr_en0 = 1; wr_addr0 = 2; wr_data0 = 32'h99; rsv_en0 = 1; rsv_addr0 = 3;
      step();
      idle0(); rd_addr_a0 = 1; rd_addr_b0 = 2;
      expect_v("mid_rst_bvec", BVEC0, 0);
      expect_v("mid_rst_rda", RDA0, 0);
      expect_v("mid_rst_rdb", RDB0, 0);
      step();

      // ---- DUT 1: ZERO_REG=1, 8 x 16 ----
      wr_en1 = 1; wr_addr1 = 0; wr_data1 = 16'hFFFF; rsv_en1 = 1; rsv_addr1 = 0;
      rd_addr_a1 = 0; rd_addr_b1 = 0;
      expect_v("z_r0_wcycle", RDA1, 0);
      expect_v("z_r0_bsa", BSA1, 0);
      step();
      idle1();
      expect_v("z_r0_after", RDB1, 0);
      expect_v("z_bvec", BVEC1, 0);
      step();
      wr_en1 = 1; wr_addr1 = 7; wr_data1 = 16'h00FF; rd_addr_a1 = 7; rd_addr_b1 = 0;
      expect_v("z_r7_byp", RDA1, 16'h00FF);
      expect_v("z_r0_still", RDB1, 0);
      step();
      idle1(); rsv_en1 = 1; rsv_addr1 = 7;
      expect_v("z_r7_stored", RDA1, 16'h00FF);
      step();
      idle1();
      expect_v("z_r7_bvec", BVEC1, 8'h80);
      expect_v("z_r7_bsa", BSA1, 1);
      step();
      reset1 = 1;
      step();
      idle1();
      expect_v("z_rst_bvec", BVEC1, 0);
      expect_v("z_rst_rda", RDA1, 0);
      expect_v("z_rst_bsa", BSA1, 0);
      step();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-register file with one synchronous write port, two combinational read ports and a per-register busy scoreboard. It generalises the team's fixed 4×32 decoder/mux register bank to NUM_REGS×DATA_W. It adds write-to-read bypass, an optional hard-wired zero register and reservation tracking for the lab datapath's issue stage. It sits between instruction decode (read/reserve) and writeback (write/release).

## Interface
- NUM_REGS, 4: register count; power of two, ≥2.
- DATA_W, 32: register width in bits.
- ZERO_REG, 0: when 1, register 0 reads 0, ignores writes and is never busy.
- ADDR_W, $clog2(NUM_REGS): address width (derived, not overridden).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; clears all registers and busy bits.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write target.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_busy_a  out  1  register at rd_addr_a is reserved.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- rd_busy_b  out  1  register at rd_addr_b is reserved.
- rsv_en  in  1  reserve strobe; sets the busy bit of rsv_addr.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy.

## Operation
- Storage: NUM_REGS × DATA_W flops. Write-enable is the one-hot decode of wr_addr, gated by wr_en.
- Write: on a clk edge with wr_en=1 and reset=0, reg[wr_addr] <= wr_data. This also clears busy[wr_addr], which is the release.
- Read: rd_data_x = reg[rd_addr_x] through an NUM_REGS:1 mux, with no added latency.
- Bypass: if wr_en=1 and wr_addr==rd_addr_x in the same cycle, rd_data_x = wr_data. Both ports may bypass at once.
- Busy: rd_busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x). The bypassed release is visible in the same cycle.
- Reserve: on a clk edge with rsv_en=1, busy[rsv_addr] <= 1.
- Same register written and reserved in one cycle: reserve wins, and busy stays 1 after the edge. The write data is still stored.
- Reserving an already-busy register leaves it busy; no count is kept.
- Writing a non-busy register stores the data and busy stays 0.
- ZERO_REG=1:
  - Writes to address 0 are dropped and are not bypassed.
  - Reads of address 0 return 0.
  - busy[0] is forced to 0, including under reserve.
- No state machine beyond storage plus scoreboard. Each busy bit is a two-state flag: FREE, RESERVED.

## Timing
- Reset values: all reg = 0, busy_vec = 0. Therefore rd_data_a/b = 0 and rd_busy_a/b = 0 in the cycle after reset.
- reset has priority over wr_en and rsv_en in the same cycle.
- A reset asserted mid-sequence discards all pending reservations and data.
- Write latency:
  - Data is visible combinationally via bypass in the write cycle.
  - Data comes from storage from the next cycle on.
- Reserve latency: busy_vec and rd_busy_x rise the cycle after rsv_en.
- Read paths are purely combinational from rd_addr_x, wr_en, wr_addr and wr_data. They have no clocked dependence within the cycle.

## Structure
Shared constants go in a regfile_pkg include:
- default DATA_W and NUM_REGS;
- the ADDR_W derivation;
- a ZERO value.

One sub-module, onehot_decoder (parametrised ADDR_W → 2^ADDR_W, with enable input), generates the write-enable and reserve-set vectors. The read muxes are inline indexed selects.

## Test plan
- Reset then read: pulse reset, set rd_addr_a=2 and rd_addr_b=3 → rd_data_a=rd_data_b=0, busy_vec=4'b0000.
- Write/read-back (NUM_REGS=4): write 0xDEADBEEF to r1, next cycle read A=r1 → 0xDEADBEEF. Read B=r2 → 0.
- Bypass: write 0x12345678 to r3 while rd_addr_a=rd_addr_b=3 → both read 0x12345678 in the same cycle. The old value is never seen.
- Scoreboard: reserve r2 → busy_vec=4'b0100 and rd_busy for r2 = 1 next cycle. Then write r2=0xA5 → rd_busy for r2 = 0 in that cycle, and busy_vec=0 after.
- Collision: reserve r1 and write r1=0x55 in one cycle → busy_vec[1]=1 after the edge, and r1 reads 0x55.
- ZERO_REG=1, NUM_REGS=8, DATA_W=16:
  - write 0xFFFF to r0 with reserve r0 → r0 reads 0 in the write cycle and after, busy_vec[0]=0;
  - write 0x00FF to r7 → 0x00FF;
  - assert reset mid-sequence → everything returns to 0.
